band_decode_sequencer: RTL and testbench

Controller that runs the 3-row ASCII decoder over a multi-band image held in the shared single-port image SRAM. It owns the SRAM port, granting it to host loads while idle and to the decoder while a job runs. It steps the decoder through bands by offsetting its addresses, and buffers decoded characters in an output FIFO with ready/valid backpressure. It sits between the host/testbench loader, the SRAM macro and one decoder instance.

---
 rtl/band_decode_sequencer_pkg.sv | 9 +
 rtl/band_decode_sequencer_sync_fifo.sv | 50 +++++
 rtl/band_decode_sequencer.sv | 125 ++++++++++++
 tb/tb_band_decode_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/band_decode_sequencer_pkg.sv
// band_decode_sequencer_pkg: shared state encoding and FIFO pointer sizing
package band_decode_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_e;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int FIFO_DEPTH_DEF = 64;
  localparam int FIFO_PTR_W = ptr_w(FIFO_DEPTH_DEF);
endpackage

// File: rtl/band_decode_sequencer_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush, occupancy and drop-on-full reporting
module sync_fifo
  import band_decode_sequencer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop = push && !do_push;
  assign count = cnt_q;
  assign free_count = (AW+1)'(DEPTH) - cnt_q;
  assign rdata = empty ? '0 : mem_q[rd_q];
  // storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
  // pointers and occupancy; a full-and-pop cycle still accepts the push
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/band_decode_sequencer.sv
// band_decode_sequencer: sequences the row decoder over image bands and owns the SRAM port
module band_decode_sequencer
  import band_decode_sequencer_pkg::*;
#(
  parameter int SRAM_DATA_WIDTH = 4,
  parameter int SRAM_ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int BAND_WIDTH = 4,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      cfg_width,
  input  logic [BAND_WIDTH-1:0]      cfg_bands,
  input  logic                       abort,
  input  logic                       host_wr_valid,
  output logic                       host_wr_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] host_wr_data,
  output logic                       sram_en,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata,
  output logic                       dec_enable,
  output logic [DATA_WIDTH-1:0]      dec_width,
  input  logic                       dec_sram_enable,
  input  logic [SRAM_ADDR_WIDTH-1:0] dec_sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] dec_sram_data,
  input  logic                       dec_valid,
  input  logic [DATA_WIDTH-1:0]      dec_out,
  input  logic                       dec_done,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       job_done,
  output logic                       cfg_err,
  output logic                       ovf
);
  localparam int CW = ptr_w(FIFO_DEPTH);
  state_e state_q;
  logic rdy_q, job_done_q, cfg_err_q, ovf_q;
  logic [DATA_WIDTH-1:0] width_q;
  logic [BAND_WIDTH-1:0] bands_q, band_cnt_q;
  logic [SRAM_ADDR_WIDTH-1:0] base_q, step_q;
  logic [15:0] w3, need;
  logic bad_cfg, run, hw, full, empty, drop, will_empty;
  logic [CW-1:0] count, free_count;
  assign w3 = 16'(cfg_width) * 16'd3;
  assign need = w3 * 16'(cfg_bands);
  assign bad_cfg = cfg_width == '0 || cfg_bands == '0 || 32'(cfg_width) > 32'(FIFO_DEPTH)
                   || 32'(need) > (32'd1 << SRAM_ADDR_WIDTH);
  assign run = state_q == RUN;
  assign host_wr_ready = rdy_q && state_q == IDLE;
  assign hw = host_wr_ready && host_wr_valid;
  assign sram_en = run ? dec_sram_enable : hw;
  assign sram_we = hw;
  assign sram_addr = run ? base_q + dec_sram_addr : hw ? host_wr_addr : '0;
  assign sram_wdata = hw ? host_wr_data : '0;
  assign dec_sram_data = run ? sram_rdata : '0;
  assign dec_enable = run;
  assign dec_width = width_q;
  assign busy = state_q != IDLE;
  assign job_done = job_done_q;
  assign cfg_err = cfg_err_q;
  assign ovf = ovf_q;
  assign out_valid = !empty;
  assign will_empty = !dec_valid && (empty || (count == CW'(1) && out_ready));
  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(abort), .push(dec_valid), .pop(out_valid && out_ready),
    .wdata(dec_out), .rdata(out_data), .full(full), .empty(empty), .drop(drop),
    .count(count), .free_count(free_count)
  );
  // job FSM; DRAIN leaves on the edge that empties the FIFO so job_done and host access line up
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      job_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      width_q    <= '0;
      bands_q    <= '0;
      band_cnt_q <= '0;
      base_q     <= '0;
      step_q     <= '0;
    end else begin
      rdy_q      <= 1'b1;
      job_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      if (drop) ovf_q <= 1'b1;
      if (abort) state_q <= IDLE;
      else case (state_q)
        IDLE: if (start) begin
          if (bad_cfg) cfg_err_q <= 1'b1;
          else begin
            state_q    <= ARM;
            width_q    <= cfg_width;
            bands_q    <= cfg_bands;
            band_cnt_q <= '0;
            base_q     <= '0;
            step_q     <= w3[SRAM_ADDR_WIDTH-1:0];
            ovf_q      <= 1'b0;
          end
        end
        ARM: if (32'(free_count) >= 32'(width_q)) state_q <= RUN;
        RUN: if (dec_done) begin
          if (band_cnt_q == bands_q - 1'b1) state_q <= DRAIN;
          else begin
            band_cnt_q <= band_cnt_q + 1'b1;
            base_q     <= base_q + step_q;
            state_q    <= ARM;
          end
        end
        DRAIN: if (will_empty) begin
          state_q    <= IDLE;
          job_done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_band_decode_sequencer.sv
// tb_band_decode_sequencer: directed checks of band sequencing, FIFO backpressure, abort and reset
module tb_band_decode_sequencer;
  logic clk = 1'b0;
  logic rst, start, abort, host_wr_valid, host_wr_ready, sram_en, sram_we;
  logic [7:0] cfg_width, dec_width, dec_out, out_data;
  logic [3:0] cfg_bands, host_wr_data, sram_wdata, sram_rdata, dec_sram_data;
  logic [6:0] host_wr_addr, sram_addr, dec_sram_addr;
  logic dec_enable, dec_sram_enable, dec_valid, dec_done, out_valid, out_ready;
  logic busy, job_done, cfg_err, ovf;
  int checks = 0, errs = 0;
  bit done;
  always #5 clk = ~clk;
  band_decode_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_bands(cfg_bands),
    .abort(abort), .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .sram_en(sram_en),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .dec_enable(dec_enable), .dec_width(dec_width), .dec_sram_enable(dec_sram_enable),
    .dec_sram_addr(dec_sram_addr), .dec_sram_data(dec_sram_data), .dec_valid(dec_valid),
    .dec_out(dec_out), .dec_done(dec_done), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .job_done(job_done), .cfg_err(cfg_err), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [7:0] w, input logic [3:0] b);
    cfg_width = w;
    cfg_bands = b;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_width = '0; cfg_bands = '0;
    host_wr_valid = 1'b1; host_wr_addr = 7'd5; host_wr_data = 4'ha; sram_rdata = '0;
    dec_sram_enable = 1'b0; dec_sram_addr = '0; dec_valid = 1'b0; dec_out = '0;
    dec_done = 1'b0; out_ready = 1'b0;
    tick;
    tick;
    chk("rst_ready", host_wr_ready, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dec_enable", dec_enable, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick;
    chk("ready_after_rst", host_wr_ready, 1);
    chk("host_en", sram_en, 1);
    chk("host_we", sram_we, 1);
    chk("host_addr", sram_addr, 5);
    chk("host_data", sram_wdata, 4'ha);
    host_wr_valid = 1'b0;
    #1;
    chk("host_idle_en", sram_en, 0);
    go(8'd43, 4'd1);
    chk("err43_pulse", cfg_err, 1);
    chk("err43_busy", busy, 0);
    tick;
    chk("err43_clear", cfg_err, 0);
    go(8'd0, 4'd1);
    chk("err0_pulse", cfg_err, 1);
    chk("err0_busy", busy, 0);
    // job 1: width 10, one band, start together with a host write
    host_wr_valid = 1'b1; host_wr_addr = 7'd7; host_wr_data = 4'h3;
    cfg_width = 8'd10; cfg_bands = 4'd1; start = 1'b1;
    #1;
    chk("j1_wr_with_start", sram_we, 1);
    chk("j1_wr_addr", sram_addr, 7);
    tick;
    start = 1'b0; host_wr_valid = 1'b0;
    chk("j1_busy", busy, 1);
    chk("j1_arm_dec_en", dec_enable, 0);
    tick;
    chk("j1_dec_en", dec_enable, 1);
    chk("j1_dec_width", dec_width, 10);
    dec_sram_enable = 1'b1; dec_sram_addr = 7'd29; sram_rdata = 4'h9;
    #1;
    chk("j1_rd_addr", sram_addr, 29);
    chk("j1_rd_en", sram_en, 1);
    chk("j1_rd_we", sram_we, 0);
    chk("j1_rd_data", dec_sram_data, 9);
    dec_sram_enable = 1'b0; sram_rdata = '0;
    for (int i = 0; i < 10; i++) begin
      dec_valid = 1'b1;
      dec_out = 8'(8'h41 + i);
      tick;
      if (i == 0) begin
        chk("j1_ov_latency", out_valid, 1);
        chk("j1_first", out_data, 8'h41);
      end
    end
    dec_valid = 1'b0;
    dec_done = 1'b1;
    tick;
    dec_done = 1'b0;
    chk("j1_done_dec_en", dec_enable, 0);
    chk("j1_drain_busy", busy, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("j1_order", out_data, 8'(8'h41 + i));
      tick;
    end
    chk("j1_job_done", job_done, 1);
    chk("j1_ready", host_wr_ready, 1);
    chk("j1_idle", busy, 0);
    chk("j1_empty", out_valid, 0);
    out_ready = 1'b0;
    tick;
    chk("j1_pulse", job_done, 0);
    // job 2: three bands of width 8, base steps by 24
    go(8'd8, 4'd3);
    tick;
    chk("j2_dec_en", dec_enable, 1);
    for (int b = 0; b < 3; b++) begin
      dec_sram_enable = 1'b1;
      dec_sram_addr = '0;
      #1;
      chk("j2_band_addr", sram_addr, 32'(b * 24));
      dec_sram_enable = 1'b0;
      dec_done = 1'b1;
      tick;
      dec_done = 1'b0;
      if (b < 2) begin
        chk("j2_gap_low", dec_enable, 0);
        tick;
        chk("j2_gap_high", dec_enable, 1);
      end
    end
    chk("j2_drain", busy, 1);
    tick;
    chk("j2_job_done", job_done, 1);
    // job 3: FIFO backpressure holds ARM until width entries are free
    go(8'd8, 4'd2);
    tick;
    for (int i = 0; i < 60; i++) begin
      dec_valid = 1'b1;
      dec_out = 8'(i);
      tick;
    end
    dec_valid = 1'b0;
    dec_done = 1'b1;
    tick;
    dec_done = 1'b0;
    chk("j3_arm_hold0", dec_enable, 0);
    tick;
    chk("j3_arm_hold1", dec_enable, 0);
    chk("j3_arm_busy", busy, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i == 2) chk("j3_hold_free7", dec_enable, 0);
    end
    out_ready = 1'b0;
    chk("j3_hold_free8", dec_enable, 0);
    tick;
    chk("j3_resume", dec_enable, 1);
    dec_done = 1'b1;
    tick;
    dec_done = 1'b0;
    out_ready = 1'b1;
    chk("j3_next_data", out_data, 4);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick;
      if (job_done) done = 1'b1;
    end
    chk("j3_job_done", done, 1);
    chk("j3_ovf", ovf, 0);
    out_ready = 1'b0;
    tick;
    // overflow is sticky, survives abort flush and clears on a new start
    for (int i = 0; i < 65; i++) begin
      dec_valid = 1'b1;
      dec_out = 8'(i);
      tick;
    end
    dec_valid = 1'b0;
    chk("ovf_set", ovf, 1);
    chk("ovf_full_valid", out_valid, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("flush_empty", out_valid, 0);
    chk("ovf_sticky", ovf, 1);
    go(8'd10, 4'd1);
    chk("ovf_cleared", ovf, 0);
    tick;
    chk("ab_run", dec_enable, 1);
    for (int i = 0; i < 5; i++) begin
      dec_valid = 1'b1;
      dec_out = 8'(i);
      tick;
    end
    dec_valid = 1'b0;
    abort = 1'b1;
    start = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_out_valid", out_valid, 0);
    chk("ab_dec_en", dec_enable, 0);
    chk("ab_job_done", job_done, 0);
    chk("ab_ready", host_wr_ready, 1);
    tick;
    chk("ab_no_done", job_done, 0);
    // reset in the middle of a job, then a clean job
    go(8'd4, 4'd1);
    tick;
    dec_valid = 1'b1;
    dec_out = 8'h55;
    tick;
    tick;
    dec_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mr_dec_en", dec_enable, 0);
    chk("mr_busy", busy, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_ready", host_wr_ready, 0);
    chk("mr_dec_width", dec_width, 0);
    tick;
    chk("mr_ready_back", host_wr_ready, 1);
    go(8'd4, 4'd1);
    tick;
    chk("mr_run", dec_enable, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec_valid = 1'b1;
      dec_out = 8'(8'h61 + i);
      tick;
      chk("mr_stream", out_data, 8'(8'h61 + i));
    end
    dec_valid = 1'b0;
    dec_done = 1'b1;
    tick;
    dec_done = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (job_done) done = 1'b1;
      else tick;
    end
    chk("mr_job_done", done, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
